// File: rtl/ram_responder_if.sv
// CPU, loader, clear and debug signal bundle between the board side and the RAM responder.
// The master modport drives the requests; the slave modport is the RAM responder itself.
interface ram_responder_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          cpu_step;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_we;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_hold;
    logic          ld_start;
    logic [AW-1:0] ld_base;
    logic [AW:0]   ld_len;
    logic          ld_valid;
    logic [DW-1:0] ld_data;
    logic          ld_ready;
    logic          ld_done;
    logic          clr_start;
    logic          clr_done;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_rdata;

    modport master (
        output cpu_step, cpu_addr, cpu_wdata, cpu_we, ld_start, ld_base, ld_len,
               ld_valid, ld_data, clr_start, dbg_addr,
        input  cpu_rdata, cpu_hold, ld_ready, ld_done, clr_done, dbg_rdata
    );

    modport slave (
        input  cpu_step, cpu_addr, cpu_wdata, cpu_we, ld_start, ld_base, ld_len,
               ld_valid, ld_data, clr_start, dbg_addr,
        output cpu_rdata, cpu_hold, ld_ready, ld_done, clr_done, dbg_rdata
    );
endinterface

// File: rtl/ram_responder.sv
// 2^AW x DW RAM serving CPU read/write, a streaming program loader, a zero-fill clear engine
// and a read-only debug port; holds the CPU while the loader or clear engine owns the write port.
module ram_responder #(
    parameter int AW        = 8,
    parameter int DW        = 8,
    parameter     INIT_FILE = ""
) (
    input logic             clk_qzt,
    input logic             reset,
    ram_responder_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CLEAR} state_t;

    state_t        r_state;
    logic [AW-1:0] r_ptr;
    logic [AW:0]   r_cnt;
    logic          r_ld_done;
    logic          r_clr_done;
    logic [DW-1:0] r_cpu_rdata;
    logic [DW-1:0] r_dbg_rdata;
    logic [DW-1:0] r_mem [2**AW];

    state_t        w_state_nxt;
    logic [AW-1:0] w_ptr_nxt;
    logic [AW:0]   w_cnt_nxt;
    logic          w_ld_done_nxt;
    logic          w_clr_done_nxt;
    logic          w_we;
    logic [AW-1:0] w_waddr;
    logic [DW-1:0] w_wdata;

    // Single write port: the CPU owns it in IDLE, the active engine owns it otherwise.
    always_comb begin
        w_state_nxt    = r_state;
        w_ptr_nxt      = r_ptr;
        w_cnt_nxt      = r_cnt;
        w_ld_done_nxt  = 1'b0;
        w_clr_done_nxt = 1'b0;
        w_we           = 1'b0;
        w_waddr        = bus.cpu_addr;
        w_wdata        = bus.cpu_wdata;
        unique case (r_state)
            S_IDLE: begin
                w_we = bus.cpu_we & bus.cpu_step;
                if (bus.ld_start) begin
                    if (bus.ld_len == '0) begin
                        w_ld_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_LOAD;
                        w_ptr_nxt   = bus.ld_base;
                        w_cnt_nxt   = bus.ld_len;
                    end
                end else if (bus.clr_start) begin
                    w_state_nxt = S_CLEAR;
                    w_ptr_nxt   = '0;
                end
            end
            S_LOAD: begin
                w_waddr = r_ptr;
                w_wdata = bus.ld_data;
                if (bus.ld_valid) begin
                    w_we      = 1'b1;
                    w_ptr_nxt = r_ptr + AW'(1);
                    w_cnt_nxt = r_cnt - (AW+1)'(1);
                    if (r_cnt == (AW+1)'(1)) begin
                        w_state_nxt   = S_IDLE;
                        w_ld_done_nxt = 1'b1;
                    end
                end
            end
            S_CLEAR: begin
                w_waddr   = r_ptr;
                w_wdata   = '0;
                w_we      = 1'b1;
                w_ptr_nxt = r_ptr + AW'(1);
                if (&r_ptr) begin
                    w_state_nxt    = S_IDLE;
                    w_clr_done_nxt = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_qzt) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_cnt       <= '0;
            r_ld_done   <= 1'b0;
            r_clr_done  <= 1'b0;
            r_cpu_rdata <= '0;
            r_dbg_rdata <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_cnt       <= w_cnt_nxt;
            r_ld_done   <= w_ld_done_nxt;
            r_clr_done  <= w_clr_done_nxt;
            r_dbg_rdata <= r_mem[bus.dbg_addr];
            if (r_state == S_IDLE) begin
                r_cpu_rdata <= r_mem[bus.cpu_addr];
            end
        end
    end

    // RAM contents survive reset; only the write is suppressed during it.
    always_ff @(posedge clk_qzt) begin
        if (w_we && !reset) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    assign bus.cpu_rdata = r_cpu_rdata;
    assign bus.dbg_rdata = r_dbg_rdata;
    assign bus.cpu_hold  = (r_state != S_IDLE);
    assign bus.ld_ready  = (r_state == S_LOAD);
    assign bus.ld_done   = r_ld_done;
    assign bus.clr_done  = r_clr_done;
endmodule
